// File: rtl/mem_ctrl.sv
// Load/store sequencer for the 64-bit big-endian RAM; sub-dword stores use read-modify-write.
// Optional MEM_CTRL_SIGN_EXT_EN adds req_signed for sign-extending sub-dword loads.
module mem_ctrl #(
  parameter int unsigned ADDR_BITS = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
`ifdef MEM_CTRL_SIGN_EXT_EN
  input  logic        req_signed,
`endif
  output logic        resp_valid,
  output logic        resp_err,
  output logic [63:0] resp_rdata,
  output logic        ram_cs,
  output logic        ram_we,
  output logic        ram_oe,
  output logic [63:0] ram_addr,
  inout  wire  [63:0] ram_data
);

  typedef enum logic [2:0] {
    StIdle, StRdSetup, StRdStrobe, StRdCapture, StWrSetup, StWrStrobe, StWrHold, StResp
  } state_e;

  localparam logic [63:0] AllOnes = '1;
  localparam logic [63:0] AddrMax = (64'd1 << ADDR_BITS) - 64'd8;

  state_e      state_q, state_d;
  logic        ready_q, resp_valid_q, resp_err_q, cs_q, we_q, oe_q, drive_q;
  logic        ready_d, resp_valid_d, resp_err_d, cs_d, we_d, oe_d, drive_d;
  logic [63:0] resp_rdata_q, resp_rdata_d, ram_addr_q, ram_addr_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        st_q, st_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q;

  logic        accept, in_range;
  logic [5:0]  sh;
  logic [63:0] keep, load_ext, merged;

  assign accept   = req_valid & ready_q;
  assign in_range = ((req_addr >> ADDR_BITS) == 64'd0) && (req_addr <= AddrMax);

`ifdef MEM_CTRL_SIGN_EXT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signed_q <= 1'b0;
    end else if (accept) begin
      signed_q <= req_signed;
    end
  end
`else
  assign signed_q = 1'b0;
`endif

  // The addressed n bytes sit at the top of the RAM word; sh moves them to/from the bottom.
  always_comb begin
    sh   = 6'd0;
    keep = 64'd0;
    unique case (size_q)
      2'd0: begin sh = 6'd56; keep = 64'h00FF_FFFF_FFFF_FFFF; end
      2'd1: begin sh = 6'd48; keep = 64'h0000_FFFF_FFFF_FFFF; end
      2'd2: begin sh = 6'd32; keep = 64'h0000_0000_FFFF_FFFF; end
      default: begin sh = 6'd0; keep = 64'd0; end
    endcase
    load_ext = ram_data >> sh;
    if (signed_q && ram_data[63]) begin
      load_ext = load_ext | ~(AllOnes >> sh);
    end
    merged = (wdata_q << sh) | (ram_data & keep);
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    st_d         = st_q;
    size_d       = size_q;
    resp_err_d   = 1'b0;
    resp_rdata_d = 64'd0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          st_d    = req_we;
          size_d  = req_size;
          if (!in_range) begin
            state_d    = StResp;
            resp_err_d = 1'b1;
          end else if (req_we && (req_size == 2'd3)) begin
            state_d = StWrSetup;
          end else begin
            state_d = StRdSetup;
          end
        end
      end
      StRdSetup:  state_d = StRdStrobe;
      StRdStrobe: state_d = StRdCapture;
      StRdCapture: begin
        if (st_q) begin
          state_d = StWrSetup;
          wdata_d = merged;
        end else begin
          state_d      = StResp;
          resp_rdata_d = load_ext;
        end
      end
      StWrSetup:  state_d = StWrStrobe;
      StWrStrobe: state_d = StWrHold;
      StWrHold:   state_d = StResp;
      StResp:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they come straight out of flops.
    ready_d      = (state_d == StIdle);
    resp_valid_d = (state_d == StResp);
    cs_d         = (state_d == StRdStrobe) || (state_d == StWrStrobe);
    oe_d         = (state_d == StRdSetup) || (state_d == StRdStrobe) || (state_d == StRdCapture);
    we_d         = (state_d == StWrSetup) || (state_d == StWrStrobe) || (state_d == StWrHold);
    drive_d      = we_d;
    ram_addr_d   = (oe_d || we_d) ? addr_d : 64'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 64'd0;
      cs_q         <= 1'b0;
      we_q         <= 1'b0;
      oe_q         <= 1'b0;
      drive_q      <= 1'b0;
      ram_addr_q   <= 64'd0;
      addr_q       <= 64'd0;
      wdata_q      <= 64'd0;
      st_q         <= 1'b0;
      size_q       <= 2'd0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      cs_q         <= cs_d;
      we_q         <= we_d;
      oe_q         <= oe_d;
      drive_q      <= drive_d;
      ram_addr_q   <= ram_addr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      st_q         <= st_d;
      size_q       <= size_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign ram_cs     = cs_q;
  assign ram_we     = we_q;
  assign ram_oe     = oe_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = drive_q ? wdata_q : 64'bz;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-array RAM model that acts on the rising edge of ram_cs.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        req_signed;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic        ram_cs, ram_we, ram_oe;
  logic [63:0] ram_addr;
  wire  [63:0] ram_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_BITS(28)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef MEM_CTRL_SIGN_EXT_EN
    .req_signed (req_signed),
`endif
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .ram_cs     (ram_cs),
    .ram_we     (ram_we),
    .ram_oe     (ram_oe),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data)
  );

  // RAM model: 1 KiB, address wraps; probe lets the bench own the bus while the DUT must be off it.
  logic [7:0]  mem [0:1023];
  logic [63:0] rd_latch = 64'd0;
  logic        probe = 1'b0;
  localparam logic [63:0] ProbePat = 64'h5A5A_5A5A_5A5A_5A5A;
  int rd_cnt = 0;
  int wr_cnt = 0;

  assign ram_data = probe ? ProbePat : ((ram_oe && !ram_we) ? rd_latch : 64'bz);

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
  end

  always @(posedge ram_cs) begin
    if (ram_we) begin
      wr_cnt++;
      for (int i = 0; i < 8; i++) mem[(int'(ram_addr[9:0]) + i) & 1023] = ram_data[63-8*i -: 8];
    end else begin
      rd_cnt++;
      for (int i = 0; i < 8; i++) rd_latch[63-8*i -: 8] = mem[(int'(ram_addr[9:0]) + i) & 1023];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(posedge clk);
      #1;
    end
    if (!req_ready) check_eq("ready_timeout", {63'd0, req_ready}, 64'd1);
  endtask

  // Issue one request and collect the response; lat counts cycles from accept edge to resp_valid.
  task automatic do_req(input logic we, input logic [1:0] size, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic sgn,
                        output int lat, output logic err, output logic [63:0] rdata);
    logic got;
    wait_ready();
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_addr   = addr;
    req_wdata  = wdata;
    req_signed = sgn;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = '1;
    req_wdata = 64'hDEAD_BEEF_F00D_CAFE;
    req_size  = ~size;
    req_we    = ~we;
    lat   = 1;
    got   = 1'b0;
    err   = 1'b0;
    rdata = 64'd0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    if (!got) check_eq("resp_timeout", {63'd0, resp_valid}, 64'd1);
    err   = resp_err;
    rdata = resp_rdata;
    @(posedge clk);
    #1;
    check_eq("resp_pulse", {63'd0, resp_valid}, 64'd0);
  endtask

  int          lat;
  logic        err;
  logic [63:0] rdata;
  int          rd0, wr0;

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'd0;
    req_addr   = 64'd0;
    req_wdata  = 64'd0;
    req_signed = 1'b0;

    #12;
    probe = 1'b1;
    #1;
    check_eq("rst_outs", {58'd0, req_ready, resp_valid, resp_err, ram_cs, ram_we, ram_oe}, 64'd0);
    check_eq("rst_rdata", resp_rdata, 64'd0);
    check_eq("rst_addr", ram_addr, 64'd0);
    check_eq("rst_bus", ram_data, ProbePat);
    probe = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("ready_held", {63'd0, req_ready}, 64'd0);
    @(posedge clk);
    #1;
    check_eq("ready_rise", {63'd0, req_ready}, 64'd1);

    // Dword store then dword load.
    do_req(1'b1, 2'd3, 64'h100, 64'h0123_4567_89AB_CDEF, 1'b0, lat, err, rdata);
    check_eq("st64_lat", 64'(lat), 64'd4);
    check_eq("st64_err", {63'd0, err}, 64'd0);
    check_eq("st64_rdata", rdata, 64'd0);
    check_eq("mem_100", {56'd0, mem[256]}, 64'h01);
    check_eq("mem_107", {56'd0, mem[263]}, 64'hEF);
    do_req(1'b0, 2'd3, 64'h100, 64'd0, 1'b0, lat, err, rdata);
    check_eq("ld64_lat", 64'(lat), 64'd4);
    check_eq("ld64_data", rdata, 64'h0123_4567_89AB_CDEF);

    // Byte store: read-modify-write with exactly one read and one write strobe.
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    do_req(1'b1, 2'd0, 64'h103, 64'h1234_5678_9ABC_DEAA, 1'b0, lat, err, rdata);
    check_eq("st8_lat", 64'(lat), 64'd7);
    check_eq("st8_reads", 64'(rd_cnt - rd0), 64'd1);
    check_eq("st8_writes", 64'(wr_cnt - wr0), 64'd1);
    check_eq("mem_10a", {56'd0, mem[266]}, 64'h50);
    do_req(1'b0, 2'd3, 64'h100, 64'd0, 1'b0, lat, err, rdata);
    check_eq("ld64_merged", rdata, 64'h0123_45AA_89AB_CDEF);

    do_req(1'b0, 2'd1, 64'h102, 64'd0, 1'b0, lat, err, rdata);
    check_eq("ld16_lat", 64'(lat), 64'd4);
    check_eq("ld16_data", rdata, 64'h0000_0000_0000_45AA);
    do_req(1'b0, 2'd2, 64'h104, 64'd0, 1'b0, lat, err, rdata);
    check_eq("ld32_data", rdata, 64'h0000_0000_89AB_CDEF);
    do_req(1'b0, 2'd0, 64'h104, 64'd0, 1'b0, lat, err, rdata);
    check_eq("ld8_zext", rdata, 64'h0000_0000_0000_0089);
`ifdef MEM_CTRL_SIGN_EXT_EN
    do_req(1'b0, 2'd0, 64'h104, 64'd0, 1'b1, lat, err, rdata);
    check_eq("ld8_sext", rdata, 64'hFFFF_FFFF_FFFF_FF89);
    do_req(1'b0, 2'd3, 64'h100, 64'd0, 1'b1, lat, err, rdata);
    check_eq("ld64_sgn_ign", rdata, 64'h0123_45AA_89AB_CDEF);
`endif

    // Range boundaries.
    rd0 = rd_cnt + wr_cnt;
    do_req(1'b0, 2'd3, 64'h1000_0000, 64'd0, 1'b0, lat, err, rdata);
    check_eq("oor_hi_lat", 64'(lat), 64'd1);
    check_eq("oor_hi_err", {63'd0, err}, 64'd1);
    check_eq("oor_hi_rdata", rdata, 64'd0);
    do_req(1'b1, 2'd0, 64'h0FFF_FFF9, 64'hFF, 1'b0, lat, err, rdata);
    check_eq("oor_top_lat", 64'(lat), 64'd1);
    check_eq("oor_top_err", {63'd0, err}, 64'd1);
    check_eq("oor_no_cs", 64'(rd_cnt + wr_cnt - rd0), 64'd0);
    do_req(1'b0, 2'd3, 64'h0FFF_FFF8, 64'd0, 1'b0, lat, err, rdata);
    check_eq("top_ok_err", {63'd0, err}, 64'd0);
    check_eq("top_ok_data", rdata, 64'hA2A3_A0A1_A6A7_A4A5);

    // Reset during RD_CAPTURE of a byte store.
    wr0 = wr_cnt;
    wait_ready();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd0;
    req_addr  = 64'h105;
    req_wdata = 64'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_eq("cap_oe", {63'd0, ram_oe}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ctl", {61'd0, ram_cs, ram_we, ram_oe}, 64'd0);
    probe = 1'b1;
    #1;
    check_eq("mid_rst_bus", ram_data, ProbePat);
    probe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("mid_rst_resp", {63'd0, resp_valid}, 64'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_eq("post_rst_resp", {63'd0, resp_valid}, 64'd0);
    end
    check_eq("rst_no_write", 64'(wr_cnt - wr0), 64'd0);
    do_req(1'b0, 2'd0, 64'h105, 64'd0, 1'b0, lat, err, rdata);
    check_eq("rst_ld_lat", 64'(lat), 64'd4);
    check_eq("rst_ld_data", rdata, 64'h0000_0000_0000_00AB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sequencer between the CPU load/store unit and the 64-bit byte-addressed, big-endian RAM.
- Accepts one request at a time through a valid/ready handshake.
- Generates the RAM's cs/we/oe/addr signals and drives the tri-state data bus.
- RAM always transfers 8 bytes, so byte/half/word stores are done as read-modify-write; loads are right-justified and extended.

Parameters:
- ADDR_BITS, 28, number of RAM address bits implemented; an access must satisfy addr[63:ADDR_BITS]==0 and addr[ADDR_BITS-1:0] <= 2^ADDR_BITS-8.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle, can accept.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  0=byte, 1=half, 2=word, 3=dword.
- req_addr  in  64  byte address; no alignment required.
- req_wdata  in  64  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  address out of range; valid with resp_valid.
- resp_rdata  out  64  load data, right-justified; 0 for stores and errors.
- ram_cs  out  1  RAM strobe; the RAM acts on the rising edge.
- ram_we  out  1  RAM write enable.
- ram_oe  out  1  RAM read enable.
- ram_addr  out  64  RAM address.
- ram_data  inout  64  RAM data bus.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs registered. While rst_n is low, all of the following are 0 and ram_data is released (Z): req_ready, resp_valid, resp_err, resp_rdata, ram_cs, ram_we, ram_oe, ram_addr. req_ready rises on the first clk edge after release.
- Handshake:
  - Accept on a clk edge where req_valid & req_ready are both high; the request fields are latched at that edge.
  - req_ready is 1 only in IDLE; one request outstanding at a time.
  - There is no response back-pressure.
- States: IDLE, RD_SETUP, RD_STROBE, RD_CAPTURE, WR_SETUP, WR_STROBE, WR_HOLD, RESP.
- Transitions from IDLE on accept:
  - out-of-range address → RESP with err=1; RAM is never strobed.
  - load, or store with size<3 → RD_SETUP.
  - store with size==3 → WR_SETUP.
- Read path:
  - RD_SETUP: addr valid, oe=1, cs=0.
  - RD_STROBE: cs=1.
  - RD_CAPTURE: cs=0; ram_data is sampled at the end of this cycle.
  - Next state: RESP for a load, WR_SETUP for a store (merge performed at the capture edge).
- Write path:
  - WR_SETUP: we=1, cs=0, data driven.
  - WR_STROBE: cs=1.
  - WR_HOLD: cs=0, data still driven.
  - Then RESP.
- ram_data is driven only in WR_SETUP, WR_STROBE and WR_HOLD; Z otherwise.
- ram_addr = latched req_addr from the first access state through WR_HOLD/RD_CAPTURE; 0 in IDLE.
- RESP: resp_valid=1 for exactly one cycle, then IDLE (req_ready=1 the following cycle).
- Latency (accept edge to resp_valid high):
  - load: 4 cycles.
  - dword store: 4 cycles.
  - sub-dword store: 7 cycles.
  - error: 1 cycle.
- Size rules: n = 1/2/4/8 bytes for size 0/1/2/3. The addressed bytes are the n most-significant bytes of the 64-bit RAM word (big-endian).
  - Load result = top n bytes of captured word >> (64-8n), zero-extended.
  - Store merge = {req_wdata[8n-1:0], old[63-8n:0]}.
- Reset mid-operation:
  - Returns to IDLE immediately; cs/we/oe drop and the bus is released.
  - No response is issued.
  - A write whose cs rising edge already occurred stands; otherwise RAM is unchanged.
- req_valid deasserting or fields changing after accept have no effect.

Optional Feature:
- Macro MEM_CTRL_SIGN_EXT_EN.
- Defined: adds input port req_signed (1 bit, latched at accept). Loads with req_signed=1 and size<3 sign-extend from bit 8n-1; req_signed is ignored for stores and dword loads.
- Undefined: port absent; all loads zero-extend.

Test Plan:
- Store dword 0x0123456789ABCDEF to 0x100, then load dword 0x100 → each resp_valid pulse 4 cycles after accept; rdata=0x0123456789ABCDEF; RAM byte 0x100=0x01, 0x107=0xEF.
- Following test 1, store byte 0xAA to 0x103 → resp_valid 7 cycles after accept, exactly one read strobe then one write strobe; load dword 0x100 → 0x012345AA89ABCDEF.
- Following test 2, load half at 0x102 → 0x00000000000045AA; load word at 0x104 → 0x0000000089ABCDEF.
- Load dword 0x0000_0000_1000_0000 (ADDR_BITS=28), and separately 0x0FFF_FFF9 → resp_err=1, resp_valid 1 cycle after accept, ram_cs stays 0 throughout.
- With MEM_CTRL_SIGN_EXT_EN, following test 2: load byte 0x104 signed → 0xFFFFFFFFFFFFFF89; same load unsigned → 0x0000000000000089.
- Byte store started, rst_n pulled low during RD_CAPTURE → cs/we/oe=0 and ram_data Z at once; no resp_valid; target bytes unchanged on later load; next request accepted normally.
